alu_arbiter: RTL and testbench

Shares one 32-bit ALU instance (function code f[2:0]: f[2] inverts b and adds carry-in; f[1:0] selects 00 AND, 01 OR, 10 SUM, 11 SLT) between two requesters.
Each requester issues an operation through a valid/ready request channel and receives the result through a valid/ready response channel.
Arbitration is round-robin or fixed-priority.
Operands and results are registered, so the ALU sits between two register stages.

---
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response channels between two requesters and the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [2:0]       req0_f;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [2:0]       req1_f;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_y;
   logic             rsp0_zero;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_y;
   logic             rsp1_zero;

   modport master (
      output req0_valid, req0_a, req0_b, req0_f, rsp0_ready,
      output req1_valid, req1_a, req1_b, req1_f, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_y, rsp0_zero,
      input  req1_ready, rsp1_valid, rsp1_y, rsp1_zero
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_f, rsp0_ready,
      input  req1_valid, req1_a, req1_b, req1_f, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_y, rsp0_zero,
      output req1_ready, rsp1_valid, rsp1_y, rsp1_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one registered 32-bit ALU (AND/OR/SUM/SLT, optional b inversion).
// Each operation walks IDLE -> EXEC -> RESP; the response is held until taken.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter bit FAIR  = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   alu_arbiter_if.slave  bus,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] op_a_reg, op_b_reg, res_y_reg;
   logic [2:0]       op_f_reg;
   logic             gnt_reg, last_gnt_reg, res_zero_reg;

   logic [1:0]       req_valid, req_ready, rsp_ready, rsp_valid;
   logic             win;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [2:0]       sel_f;
   logic [WIDTH-1:0] alu_b, alu_sum, alu_y;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

   // On a tie, round-robin favours whoever was not served last.
   always_comb begin
      win = req_valid[1];
      if (req_valid == 2'b11) begin
         win = FAIR ? ~last_gnt_reg : 1'b0;
      end
   end

   assign sel_a = win ? bus.req1_a : bus.req0_a;
   assign sel_b = win ? bus.req1_b : bus.req0_b;
   assign sel_f = win ? bus.req1_f : bus.req0_f;

   always_comb begin
      alu_b   = op_f_reg[2] ? ~op_b_reg : op_b_reg;
      alu_sum = op_a_reg + alu_b + {{(WIDTH-1){1'b0}}, op_f_reg[2]};
      case (op_f_reg[1:0])
         2'b00:   alu_y = op_a_reg & alu_b;
         2'b01:   alu_y = op_a_reg | alu_b;
         2'b10:   alu_y = alu_sum;
         default: alu_y = {{(WIDTH-1){1'b0}}, alu_sum[WIDTH-1]};
      endcase
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 2'b00;
      rsp_valid  = 2'b00;
      case (state_reg)
         IDLE: begin
            // reset_n gating keeps ready low while reset is held
            if ((|req_valid) && reset_n) begin
               req_ready[win] = 1'b1;
               state_next     = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            rsp_valid[gnt_reg] = 1'b1;
            if (rsp_ready[gnt_reg]) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         op_f_reg     <= '0;
         gnt_reg      <= 1'b0;
         last_gnt_reg <= 1'b1;
         res_y_reg    <= '0;
         res_zero_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && state_next == EXEC) begin
            op_a_reg <= sel_a;
            op_b_reg <= sel_b;
            op_f_reg <= sel_f;
            gnt_reg  <= win;
         end
         if (state_reg == EXEC) begin
            res_y_reg    <= alu_y;
            res_zero_reg <= (alu_y == '0);
         end
         if (state_reg == RESP && state_next == IDLE) begin
            last_gnt_reg <= gnt_reg;
         end
      end
   end

   assign bus.req0_ready = req_ready[0];
   assign bus.req1_ready = req_ready[1];
   assign bus.rsp0_valid = rsp_valid[0];
   assign bus.rsp1_valid = rsp_valid[1];
   assign bus.rsp0_y     = rsp_valid[0] ? res_y_reg : '0;
   assign bus.rsp1_y     = rsp_valid[1] ? res_y_reg : '0;
   assign bus.rsp0_zero  = rsp_valid[0] & res_zero_reg;
   assign bus.rsp1_zero  = rsp_valid[1] & res_zero_reg;
   assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: vector table of single operations, plus arbitration, backpressure and reset sequences.
// A FAIR=0 instance mirrors the request inputs of the FAIR=1 instance.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic busy, busy_fp;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(32)) bus ();
   alu_arbiter_if #(.WIDTH(32)) bus_fp ();

   assign bus_fp.req0_valid = bus.req0_valid;
   assign bus_fp.req0_a     = bus.req0_a;
   assign bus_fp.req0_b     = bus.req0_b;
   assign bus_fp.req0_f     = bus.req0_f;
   assign bus_fp.req1_valid = bus.req1_valid;
   assign bus_fp.req1_a     = bus.req1_a;
   assign bus_fp.req1_b     = bus.req1_b;
   assign bus_fp.req1_f     = bus.req1_f;
   assign bus_fp.rsp0_ready = bus.rsp0_ready;
   assign bus_fp.rsp1_ready = bus.rsp1_ready;

   alu_arbiter #(.WIDTH(32), .FAIR(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy));
   alu_arbiter #(.WIDTH(32), .FAIR(1'b0)) dut_fp (
      .clk(clk), .reset_n(reset_n), .bus(bus_fp), .busy(busy_fp));

   typedef struct {
      logic        port;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [31:0] y;
      logic        zero;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic port, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] f);
      if (port == 1'b0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_f = f;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_f = f;
      end
   endtask

   // Full transaction with the response taken at once; checks cycle-exact timing.
   task automatic run_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] exp_y, input logic exp_zero);
      logic accepted;
      logic my_ready, other_ready;
      logic [31:0] got_y;
      @(negedge clk);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      drive_req(port, 1'b1, a, b, f);
      #1;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         my_ready    = port ? bus.req1_ready : bus.req0_ready;
         other_ready = port ? bus.req0_ready : bus.req1_ready;
         if (my_ready) accepted = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      check("accept", {31'b0, accepted}, 32'd1);
      check("other_ready_idle", {31'b0, other_ready}, 32'd0);
      if (!accepted) begin
         drive_req(port, 1'b0, '0, '0, '0);
         return;
      end
      @(posedge clk);
      #1 drive_req(port, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("exec_busy", {31'b0, busy}, 32'd1);
      check("exec_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
      check("exec_rsp_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      @(negedge clk);
      check("resp_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, port ? 32'd2 : 32'd1);
      got_y = port ? bus.rsp1_y : bus.rsp0_y;
      check("resp_y", got_y, exp_y);
      check("resp_zero", {31'b0, port ? bus.rsp1_zero : bus.rsp0_zero}, {31'b0, exp_zero});
      check("resp_other_y", port ? bus.rsp0_y : bus.rsp1_y, 32'd0);
      check("resp_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("done_busy", {31'b0, busy}, 32'd0);
      check("done_rsp_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      $display("op port=%0d a=%h b=%h f=%b y=%h expected=%h", port, a, b, f, got_y, exp_y);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int g_rr[4];
      int g_fp[4];
      int n_rr, n_fp;
      int exp_rr[4];
      int saw_rsp;

      vecs[0] = '{1'b0, 32'd5,          32'd7,          3'b010, 32'd12,         1'b0};
      vecs[1] = '{1'b1, 32'd9,          32'd9,          3'b110, 32'd0,          1'b1};
      vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'd1,          3'b111, 32'd1,          1'b0};
      vecs[3] = '{1'b1, 32'd1,          32'hFFFFFFFF,   3'b111, 32'd0,          1'b1};
      vecs[4] = '{1'b0, 32'hF0F0F0F0,   32'h0FF00FF0,   3'b000, 32'h00F000F0,   1'b0};
      vecs[5] = '{1'b1, 32'hF0F0F0F0,   32'h0FF00FF0,   3'b001, 32'hFFF0FFF0,   1'b0};
      exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;

      // Reset with a request pending: everything must stay quiet
      reset_n = 1'b0;
      drive_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
      drive_req(1'b1, 1'b0, '0, '0, '0);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
      check("rst_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      drive_req(1'b0, 1'b0, '0, '0, '0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_y", bus.rsp0_y, 32'd0);

      // Both requesters contend continuously for 4 operations
      @(negedge clk);
      drive_req(1'b0, 1'b1, 32'd10, 32'd3, 3'b010);
      drive_req(1'b1, 1'b1, 32'd10, 32'd3, 3'b110);
      n_rr = 0; n_fp = 0;
      for (int i = 0; i < 4; i++) begin g_rr[i] = -1; g_fp[i] = -1; end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.rsp0_valid && n_rr < 4) begin
            g_rr[n_rr] = 0; n_rr++;
            check("rr_y0", bus.rsp0_y, 32'd13);
         end else if (bus.rsp1_valid && n_rr < 4) begin
            g_rr[n_rr] = 1; n_rr++;
            check("rr_y1", bus.rsp1_y, 32'd7);
         end
         if (bus_fp.rsp0_valid && n_fp < 4) begin
            g_fp[n_fp] = 0; n_fp++;
         end else if (bus_fp.rsp1_valid && n_fp < 4) begin
            g_fp[n_fp] = 1; n_fp++;
         end
      end
      drive_req(1'b0, 1'b0, '0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_grant%0d", i), g_rr[i], exp_rr[i]);
         check($sformatf("fixed_grant%0d", i), g_fp[i], 32'd0);
         $display("arb op=%0d fair_grant=%0d fixed_grant=%0d", i, g_rr[i], g_fp[i]);
      end
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].y, vecs[i].zero);
      end

      // Backpressure: result held for 5 cycles while requester 1 waits
      @(negedge clk);
      bus.rsp0_ready = 1'b0;
      drive_req(1'b0, 1'b1, 32'd3, 32'd4, 3'b010);
      #1 check("bp_accept", {31'b0, bus.req0_ready}, 32'd1);
      @(posedge clk);
      #1 drive_req(1'b0, 1'b0, '0, '0, '0);
      drive_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b010);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", {31'b0, bus.rsp0_valid}, 32'd1);
         check("bp_y", bus.rsp0_y, 32'd7);
         check("bp_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
         check("bp_busy", {31'b0, busy}, 32'd1);
      end
      $display("op port=0 a=00000003 b=00000004 f=010 y=%h expected=00000007 (held)", bus.rsp0_y);
      bus.rsp0_ready = 1'b1;
      @(negedge clk);
      check("bp_release_busy", {31'b0, busy}, 32'd0);
      check("bp_release_valid", {31'b0, bus.rsp0_valid}, 32'd0);
      drive_req(1'b1, 1'b0, '0, '0, '0);
      @(negedge clk);

      // Reset asserted while in EXEC
      drive_req(1'b0, 1'b1, 32'd100, 32'd1, 3'b010);
      @(posedge clk);
      #1 drive_req(1'b0, 1'b0, '0, '0, '0);
      drive_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b010);
      check("pre_rst_busy", {31'b0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
      check("mid_rst_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      check("mid_rst_y", bus.rsp0_y, 32'd0);
      @(negedge clk);
      drive_req(1'b1, 1'b0, '0, '0, '0);
      @(negedge clk);
      reset_n = 1'b1;
      saw_rsp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.rsp0_valid || bus.rsp1_valid || busy) saw_rsp++;
      end
      check("no_rsp_after_rst", saw_rsp, 32'd0);
      run_op(1'b0, 32'd2, 32'd3, 3'b010, 32'd5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
